// File: rtl/harmonic_mixer_pkg.sv
// Shared types, widths and saturation helper for the harmonic mixer.
package harmonic_mixer_pkg;

  localparam int unsigned NUM_HARM_DEF = 3;
  localparam int unsigned TIMEOUT_DEF  = 64;
  localparam int unsigned SAMPLE_W     = 16;
  localparam int unsigned ACC_W        = SAMPLE_W + 2;

  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, REQ, WAIT, SUM, OUT} state_t;

  // Clamp the wide accumulator into the signed sample range.
  function automatic logic signed [SAMPLE_W-1:0] sat_clamp(input logic signed [ACC_W-1:0] a);
    if (a > ACC_W'(SAMPLE_MAX)) return SAMPLE_MAX;
    if (a < ACC_W'(SAMPLE_MIN)) return SAMPLE_MIN;
    return SAMPLE_W'(a);
  endfunction

endpackage

// File: rtl/harmonic_mixer_if.sv
// Harmonic-source handshake and codec-side mix bus.
interface harmonic_mixer_if import harmonic_mixer_pkg::*; #(
  parameter int unsigned NUM_HARM = NUM_HARM_DEF
) ();

  logic                         play_enable;
  logic                         new_frame;
  logic [NUM_HARM-1:0]          harm_enable;
  logic [NUM_HARM-1:0]          harm_sample_ready;
  logic [NUM_HARM*SAMPLE_W-1:0] harm_sample_in;
  logic [NUM_HARM-1:0]          generate_next_sample;
  logic signed [SAMPLE_W-1:0]   mix_out;
  logic                         mix_valid;
  logic                         timeout_err;
  logic                         overrun_err;

  modport master (
    output play_enable, new_frame, harm_enable, harm_sample_ready, harm_sample_in,
    input  generate_next_sample, mix_out, mix_valid, timeout_err, overrun_err
  );

  modport slave (
    input  play_enable, new_frame, harm_enable, harm_sample_ready, harm_sample_in,
    output generate_next_sample, mix_out, mix_valid, timeout_err, overrun_err
  );

endinterface

// File: rtl/harmonic_capture_slot.sv
// Per-source capture register with a captured flag; first load per frame wins.
module harmonic_capture_slot import harmonic_mixer_pkg::*; (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       load,
  input  logic signed [SAMPLE_W-1:0] d,
  output logic signed [SAMPLE_W-1:0] q,
  output logic                       captured
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q        <= '0;
      captured <= 1'b0;
    end else if (clear) begin
      q        <= '0;
      captured <= 1'b0;
    end else if (load) begin
      q        <= d;
      captured <= 1'b1;
    end
  end

endmodule

// File: rtl/harmonic_mixer.sv
// Requests one sample per harmonic each codec frame, sums captures with saturation.
module harmonic_mixer import harmonic_mixer_pkg::*; #(
  parameter int unsigned NUM_HARM = NUM_HARM_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input logic             clk,
  input logic             reset,
  harmonic_mixer_if.slave bus
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned IDX_W = (NUM_HARM > 1) ? $clog2(NUM_HARM) : 1;

  state_t                     state, state_d;
  logic [NUM_HARM-1:0]        en_q, en_d, gns_q, gns_d;
  logic [NUM_HARM-1:0]        cap_flag, cap_load;
  logic                       cap_clear, all_cap;
  logic signed [SAMPLE_W-1:0] cap_val [NUM_HARM];
  logic signed [ACC_W-1:0]    acc_q, acc_d, addend;
  logic [CNT_W-1:0]           wait_q, wait_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic signed [SAMPLE_W-1:0] mix_q, mix_d;
  logic                       valid_q, valid_d, tmo_q, tmo_d, ovr_q, ovr_d;

  // Only the first ready pulse from an enabled source counts, and only while waiting.
  assign cap_load = (state == WAIT) ? (en_q & bus.harm_sample_ready & ~cap_flag) : '0;
  assign all_cap  = (((cap_flag | cap_load) & en_q) == en_q);

  for (genvar i = 0; i < NUM_HARM; i++) begin : g_slot
    harmonic_capture_slot u_slot (
      .clk      (clk),
      .reset    (reset),
      .clear    (cap_clear),
      .load     (cap_load[i]),
      .d        (bus.harm_sample_in[i*SAMPLE_W +: SAMPLE_W]),
      .q        (cap_val[i]),
      .captured (cap_flag[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      en_q    <= '0;
      gns_q   <= '0;
      acc_q   <= '0;
      wait_q  <= '0;
      idx_q   <= '0;
      mix_q   <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state   <= state_d;
      en_q    <= en_d;
      gns_q   <= gns_d;
      acc_q   <= acc_d;
      wait_q  <= wait_d;
      idx_q   <= idx_d;
      mix_q   <= mix_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
    end
  end

  // Outputs are computed one cycle ahead so they line up with the state they belong to.
  always_comb begin
    state_d   = state;
    en_d      = en_q;
    gns_d     = '0;
    acc_d     = acc_q;
    wait_d    = wait_q;
    idx_d     = idx_q;
    mix_d     = mix_q;
    valid_d   = 1'b0;
    tmo_d     = tmo_q;
    ovr_d     = ovr_q;
    cap_clear = 1'b0;
    addend    = '0;

    for (int i = 0; i < NUM_HARM; i++) begin
      if (idx_q == IDX_W'(i) && cap_flag[i]) addend = ACC_W'(cap_val[i]);
    end

    if (bus.new_frame && state != IDLE) ovr_d = 1'b1;

    case (state)
      IDLE: begin
        if (bus.new_frame) begin
          acc_d = '0;
          if (bus.play_enable) begin
            en_d      = bus.harm_enable;
            gns_d     = bus.harm_enable;
            cap_clear = 1'b1;
            state_d   = REQ;
          end else begin
            mix_d   = '0;
            valid_d = 1'b1;
            state_d = OUT;
          end
        end
      end
      REQ: begin
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (all_cap) begin
          idx_d   = '0;
          state_d = SUM;
        end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          idx_d   = '0;
          state_d = SUM;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      SUM: begin
        acc_d = acc_q + addend;
        if (idx_q == IDX_W'(NUM_HARM - 1)) begin
          mix_d   = sat_clamp(acc_d);
          valid_d = 1'b1;
          state_d = OUT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.generate_next_sample = gns_q;
  assign bus.mix_out              = mix_q;
  assign bus.mix_valid            = valid_q;
  assign bus.timeout_err          = tmo_q;
  assign bus.overrun_err          = ovr_q;

endmodule

// File: tb/tb_harmonic_mixer.sv
// Directed checks of harmonic_mixer: mixing, saturation, masking, timeout, silence, overrun, reset.
module tb_harmonic_mixer;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  harmonic_mixer_if #(.NUM_HARM(3)) bus ();

  harmonic_mixer #(.NUM_HARM(3), .TIMEOUT(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_samples(input int a, input int b, input int c);
    bus.harm_sample_in = {16'(c), 16'(b), 16'(a)};
  endtask

  function automatic int gns();
    return int'(bus.generate_next_sample);
  endfunction

  function automatic int mix();
    return int'(bus.mix_out);
  endfunction

  // All three sources answer two cycles after new_frame; result due at t+6.
  task automatic quick_frame(input int a, input int b, input int c, input int exp, input string tag);
    set_samples(a, b, c);
    bus.harm_enable = 3'b111;
    bus.play_enable = 1'b1;
    bus.new_frame   = 1'b1;
    step();
    bus.new_frame = 1'b0;
    chk({tag, "_gns"}, gns(), 7);
    step();
    chk({tag, "_gns_once"}, gns(), 0);
    bus.harm_sample_ready = 3'b111;
    step();
    bus.harm_sample_ready = 3'b000;
    step(2);
    chk({tag, "_valid_early"}, int'(bus.mix_valid), 0);
    step();
    chk({tag, "_valid"}, int'(bus.mix_valid), 1);
    chk({tag, "_mix"}, mix(), exp);
    step();
  endtask

  initial begin
    int rdy_seq [8] = '{2, 0, 2, 3, 1, 0, 2, 4};

    bus.play_enable       = 1'b0;
    bus.new_frame         = 1'b0;
    bus.harm_enable       = '0;
    bus.harm_sample_ready = '0;
    bus.harm_sample_in    = '0;

    #1;
    chk("rst_gns",   gns(), 0);
    chk("rst_mix",   mix(), 0);
    chk("rst_valid", int'(bus.mix_valid), 0);
    chk("rst_tmo",   int'(bus.timeout_err), 0);
    chk("rst_ovr",   int'(bus.overrun_err), 0);
    step(2);
    reset = 1'b1;
    step();

    quick_frame(1000, 2000, -500, 2500, "basic");
    chk("basic_hold", mix(), 2500);
    chk("basic_valid_pulse", int'(bus.mix_valid), 0);
    chk("basic_tmo", int'(bus.timeout_err), 0);
    chk("basic_ovr", int'(bus.overrun_err), 0);

    quick_frame(30000, 10000, 0, 32767, "sat_pos");
    quick_frame(-30000, -10000, -1, -32768, "sat_neg");

    // Masked source 1 toggles; source 0 pulses twice with a different second value.
    bus.harm_enable = 3'b101;
    set_samples(700, 12345, -200);
    bus.new_frame = 1'b1;
    step();
    bus.new_frame = 1'b0;
    chk("mask_gns", gns(), 5);
    step();
    for (int k = 0; k < 8; k++) begin
      set_samples((k == 4) ? 5000 : 700, 12345, -200);
      bus.harm_sample_ready = 3'(rdy_seq[k]);
      step();
    end
    bus.harm_sample_ready = 3'b000;
    step(2);
    chk("mask_valid_early", int'(bus.mix_valid), 0);
    step();
    chk("mask_valid", int'(bus.mix_valid), 1);
    chk("mask_mix", mix(), 500);
    step();

    // Source 2 never answers.
    bus.harm_enable = 3'b111;
    set_samples(100, 200, 7777);
    bus.new_frame = 1'b1;
    step();
    bus.new_frame = 1'b0;
    step();
    bus.harm_sample_ready = 3'b011;
    step();
    bus.harm_sample_ready = 3'b000;
    step(62);
    chk("tmo_not_yet", int'(bus.timeout_err), 0);
    step();
    chk("tmo_set", int'(bus.timeout_err), 1);
    step(3);
    chk("tmo_valid", int'(bus.mix_valid), 1);
    chk("tmo_mix", mix(), 300);
    step();

    // Silence frame.
    bus.play_enable = 1'b0;
    bus.new_frame   = 1'b1;
    step();
    bus.new_frame = 1'b0;
    chk("sil_gns", gns(), 0);
    chk("sil_valid", int'(bus.mix_valid), 1);
    chk("sil_mix", mix(), 0);
    chk("tmo_sticky", int'(bus.timeout_err), 1);
    step();

    // Overrun: extra new_frame while waiting.
    bus.play_enable = 1'b1;
    bus.harm_enable = 3'b011;
    set_samples(111, 222, 0);
    bus.new_frame = 1'b1;
    step();
    bus.new_frame = 1'b0;
    chk("ovr_gns", gns(), 3);
    step();
    bus.new_frame = 1'b1;
    step();
    bus.new_frame = 1'b0;
    chk("ovr_set", int'(bus.overrun_err), 1);
    chk("ovr_no_req", gns(), 0);
    bus.harm_sample_ready = 3'b011;
    step();
    bus.harm_sample_ready = 3'b000;
    step(3);
    chk("ovr_valid", int'(bus.mix_valid), 1);
    chk("ovr_mix", mix(), 333);
    step();

    // Reset asserted in WAIT, away from the clock edge.
    bus.harm_enable = 3'b111;
    bus.new_frame   = 1'b1;
    step();
    bus.new_frame = 1'b0;
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_gns", gns(), 0);
    chk("mrst_mix", mix(), 0);
    chk("mrst_valid", int'(bus.mix_valid), 0);
    chk("mrst_tmo", int'(bus.timeout_err), 0);
    chk("mrst_ovr", int'(bus.overrun_err), 0);
    step(2);
    reset = 1'b1;
    step();

    quick_frame(-1000, 300, 50, -650, "post_rst");
    chk("post_rst_tmo", int'(bus.timeout_err), 0);
    chk("post_rst_ovr", int'(bus.overrun_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
